// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue controller: default parameters,
// add/sub opcode values and the response record stored in the result FIFO.
package fpu_pkg;

    localparam int unsigned FPU_LAT_DEF = 2;
    localparam int unsigned DEPTH_DEF   = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // One FPU result with its overflow/underflow flags
    typedef struct packed {
        logic [31:0] s;
        logic        ov;
        logic        un;
    } fpu_rsp_t;

endpackage

// File: rtl/fpu_rsp_fifo.sv
// Result FIFO holding FPU responses until the consumer pops them.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   wr_en       push wr_data this cycle
//   wr_data     response to push
//   rd_en       pop the head this cycle (ignored when empty)
//   rd_data     current head entry
//   count       number of occupied entries (0..DEPTH)
module fpu_rsp_fifo
    import fpu_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  fpu_rsp_t               wr_data,
    input  logic                   rd_en,
    output fpu_rsp_t               rd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fpu_rsp_t          mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              do_rd;
    logic              full;

    assign do_rd   = rd_en && (cnt != '0);
    assign full    = (cnt == CW'(DEPTH));
    assign rd_data = mem[rd_ptr];
    assign count   = cnt;

    // Storage, pointers (wrap naturally at power-of-2 depth) and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, do_rd})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Credits upstream must make overflow impossible
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && full && !do_rd));

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue controller for a fixed-latency add/sub FPU. Registers operands to the
// FPU, tracks in-flight ops with a valid pipe, captures results into an
// in-order FIFO and throttles requests with credits so the FIFO never overflows.
// Ports:
//   i_clk, i_rst_n                        clock, async active-low reset
//   i_req_valid/o_req_ready               request handshake
//   i_req_add_sub, i_req_a, i_req_b       opcode and operands
//   o_fpu_add_sub, o_fpu_a, o_fpu_b       registered operands to the FPU
//   i_fpu_s, i_fpu_ov, i_fpu_un           FPU result and flags
//   o_rsp_valid/i_rsp_ready               response handshake
//   o_rsp_s, o_rsp_ov, o_rsp_un           FIFO head
//   o_sticky_ov, o_sticky_un, i_clr_sticky accumulated flags and clear
//   o_busy                                ops in flight or results buffered
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned NUM_OP  = 1,
    parameter int unsigned FPU_LAT = FPU_LAT_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [NUM_OP-1:0] i_req_add_sub,
    input  logic [31:0]       i_req_a,
    input  logic [31:0]       i_req_b,
    output logic [NUM_OP-1:0] o_fpu_add_sub,
    output logic [31:0]       o_fpu_a,
    output logic [31:0]       o_fpu_b,
    input  logic [31:0]       i_fpu_s,
    input  logic              i_fpu_ov,
    input  logic              i_fpu_un,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_s,
    output logic              o_rsp_ov,
    output logic              o_rsp_un,
    output logic              o_sticky_ov,
    output logic              o_sticky_un,
    input  logic              i_clr_sticky,
    output logic              o_busy
);

    localparam int unsigned CRW = $clog2(DEPTH + 1);
    localparam int unsigned CW  = $clog2(DEPTH) + 1;

    logic [FPU_LAT:0] v;
    logic [CRW-1:0]   credit;
    logic [CRW-1:0]   credit_nxt;
    logic             ready_q;
    logic             accept;
    logic             pop;
    logic             fifo_wr;
    logic [CW-1:0]    fifo_count;
    fpu_rsp_t         wr_rsp;
    fpu_rsp_t         head;

    assign accept  = i_req_valid && ready_q;
    assign pop     = o_rsp_valid && i_rsp_ready;
    assign fifo_wr = v[FPU_LAT];
    assign wr_rsp  = '{s: i_fpu_s, ov: i_fpu_ov, un: i_fpu_un};

    // Credit update: accept consumes, pop returns, both together cancel
    always_comb begin
        credit_nxt = credit;
        case ({accept, pop})
            2'b10:   credit_nxt = credit - CRW'(1);
            2'b01:   credit_nxt = credit + CRW'(1);
            default: credit_nxt = credit;
        endcase
    end

    // Ready tracks the registered credit only, so a same-cycle pop cannot raise it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            credit  <= CRW'(DEPTH);
            ready_q <= 1'b1;
        end else begin
            credit  <= credit_nxt;
            ready_q <= (credit_nxt != '0);
        end
    end

    // Operand registers and in-flight valid pipe
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v             <= '0;
            o_fpu_add_sub <= '0;
            o_fpu_a       <= '0;
            o_fpu_b       <= '0;
        end else begin
            v <= {v[FPU_LAT-1:0], accept};
            if (accept) begin
                o_fpu_add_sub <= i_req_add_sub;
                o_fpu_a       <= i_req_a;
                o_fpu_b       <= i_req_b;
            end
        end
    end

    // Sticky flags: a new flag on this write beats a simultaneous clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sticky_ov <= 1'b0;
            o_sticky_un <= 1'b0;
        end else begin
            o_sticky_ov <= (fifo_wr && i_fpu_ov) || (o_sticky_ov && !i_clr_sticky);
            o_sticky_un <= (fifo_wr && i_fpu_un) || (o_sticky_un && !i_clr_sticky);
        end
    end

    fpu_rsp_fifo #(
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .wr_en   (fifo_wr),
        .wr_data (wr_rsp),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_count)
    );

    assign o_req_ready = ready_q;
    assign o_rsp_valid = (fifo_count != '0);
    assign o_rsp_s     = head.s;
    assign o_rsp_ov    = head.ov;
    assign o_rsp_un    = head.un;
    assign o_busy      = (|v) || (fifo_count != '0);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a two-stage FPU stand-in.
module tb_fpu_issue_ctrl;
    import fpu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        o_req_ready;
    logic [0:0]  req_add_sub;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [0:0]  o_fpu_add_sub;
    logic [31:0] o_fpu_a;
    logic [31:0] o_fpu_b;
    logic [31:0] fpu_s;
    logic        fpu_ov;
    logic        fpu_un;
    logic        o_rsp_valid;
    logic        rsp_ready;
    logic [31:0] o_rsp_s;
    logic        o_rsp_ov;
    logic        o_rsp_un;
    logic        o_sticky_ov;
    logic        o_sticky_un;
    logic        clr_sticky;
    logic        o_busy;

    int          checks = 0;
    int          errors = 0;
    logic [33:0] q[$];
    int          qbase;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fpu_issue_ctrl #(
        .NUM_OP  (1),
        .FPU_LAT (2),
        .DEPTH   (4)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_add_sub (req_add_sub),
        .i_req_a       (req_a),
        .i_req_b       (req_b),
        .o_fpu_add_sub (o_fpu_add_sub),
        .o_fpu_a       (o_fpu_a),
        .o_fpu_b       (o_fpu_b),
        .i_fpu_s       (fpu_s),
        .i_fpu_ov      (fpu_ov),
        .i_fpu_un      (fpu_un),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_s       (o_rsp_s),
        .o_rsp_ov      (o_rsp_ov),
        .o_rsp_un      (o_rsp_un),
        .o_sticky_ov   (o_sticky_ov),
        .o_sticky_un   (o_sticky_un),
        .i_clr_sticky  (clr_sticky),
        .o_busy        (o_busy)
    );

    // FPU stand-in: known float vectors; small positive denormals add/sub exactly as integers
    function automatic logic [33:0] fpu_model(input logic op, input logic [31:0] a, input logic [31:0] b);
        if (!op && a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, 2'b00};
        if (op && a == 32'h40400000 && b == 32'h3F800000)  return {32'h40000000, 2'b00};
        if (!op && a == 32'h7F7FFFFF && b == 32'h7F7FFFFF) return {32'h7F800000, 2'b10};
        return op ? {a - b, 2'b00} : {a + b, 2'b00};
    endfunction

    logic [64:0] p1;
    logic [64:0] p2;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1 <= '0;
            p2 <= '0;
        end else begin
            p1 <= {o_fpu_add_sub, o_fpu_a, o_fpu_b};
            p2 <= p1;
        end
    end
    assign {fpu_s, fpu_ov, fpu_un} = fpu_model(p2[64], p2[63:32], p2[31:0]);

    // Record every response actually popped
    always @(posedge clk) begin
        if (rst_n && o_rsp_valid && rsp_ready) q.push_back({o_rsp_s, o_rsp_ov, o_rsp_un});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold the request until accepted, return on the negedge after acceptance
    task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        req_valid   = 1'b1;
        req_add_sub = op;
        req_a       = a;
        req_b       = b;
        while (!o_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", 32'(o_req_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_valid(input int maxc, output int n);
        n = 0;
        while (!o_rsp_valid && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int          n;
        int          acc;
        int          bad;
        logic        rdy;
        logic [33:0] r;

        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_add_sub = '0;
        req_a       = '0;
        req_b       = '0;
        rsp_ready   = 1'b0;
        clr_sticky  = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_fpu_a", o_fpu_a, 32'd0);
        check("rst_sticky_ov", 32'(o_sticky_ov), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(o_req_ready), 32'd1);

        // 1.0 + 2.0 = 3.0, response three cycles after acceptance
        rsp_ready = 1'b1;
        send(OP_ADD, 32'h3F800000, 32'h40000000);
        req_valid = 1'b0;
        check("add_fpu_a", o_fpu_a, 32'h3F800000);
        check("add_fpu_b", o_fpu_b, 32'h40000000);
        check("add_fpu_op", 32'(o_fpu_add_sub), 32'd0);
        check("add_busy", 32'(o_busy), 32'd1);
        wait_valid(6, n);
        check("add_latency", 32'(n), 32'd3);
        check("add_s", o_rsp_s, 32'h40400000);
        check("add_ov", 32'(o_rsp_ov), 32'd0);
        check("add_un", 32'(o_rsp_un), 32'd0);
        @(negedge clk);
        check("add_popped", 32'(o_rsp_valid), 32'd0);
        check("add_idle", 32'(o_busy), 32'd0);
        check("fpu_a_hold", o_fpu_a, 32'h3F800000);

        // 3.0 - 1.0 = 2.0
        send(OP_SUB, 32'h40400000, 32'h3F800000);
        req_valid = 1'b0;
        check("sub_fpu_op", 32'(o_fpu_add_sub), 32'd1);
        wait_valid(6, n);
        check("sub_latency", 32'(n), 32'd3);
        check("sub_s", o_rsp_s, 32'h40000000);
        @(negedge clk);

        // Back-to-back stream, results in order
        qbase = q.size();
        for (int i = 0; i < 8; i++) send(OP_ADD, 32'(i + 1), 32'h10);
        req_valid = 1'b0;
        n = 0;
        while (q.size() - qbase < 8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_count", 32'(q.size() - qbase), 32'd8);
        for (int i = 0; i < 8; i++) begin
            r = (qbase + i < q.size()) ? q[qbase + i] : '0;
            check($sformatf("b2b_%0d", i), r[33:2], 32'(i + 17));
        end

        // Consumer stalled: only DEPTH requests get in
        qbase     = q.size();
        rsp_ready = 1'b0;
        acc       = 0;
        for (int c = 0; c < 6; c++) begin
            req_valid   = 1'b1;
            req_add_sub = OP_ADD;
            req_a       = 32'h100 + 32'(acc);
            req_b       = 32'h1;
            rdy         = o_req_ready;
            @(negedge clk);
            if (rdy) acc++;
        end
        req_valid = 1'b0;
        check("stall_accepted", 32'(acc), 32'd4);
        check("stall_not_ready", 32'(o_req_ready), 32'd0);
        check("stall_valid", 32'(o_rsp_valid), 32'd1);
        check("stall_head", o_rsp_s, 32'h101);
        @(negedge clk);
        check("stall_head_stable", o_rsp_s, 32'h101);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("pop_ready_back", 32'(o_req_ready), 32'd1);
        check("pop_next_head", o_rsp_s, 32'h102);
        rsp_ready = 1'b1;
        n = 0;
        while (q.size() - qbase < 4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("stall_count", 32'(q.size() - qbase), 32'd4);
        for (int i = 0; i < 4; i++) begin
            r = (qbase + i < q.size()) ? q[qbase + i] : '0;
            check($sformatf("stall_order_%0d", i), r[33:2], 32'h101 + 32'(i));
        end

        // Overflow flag and sticky behaviour
        send(OP_ADD, 32'h7F7FFFFF, 32'h7F7FFFFF);
        req_valid = 1'b0;
        wait_valid(6, n);
        check("ov_s", o_rsp_s, 32'h7F800000);
        check("ov_flag", 32'(o_rsp_ov), 32'd1);
        check("ov_sticky", 32'(o_sticky_ov), 32'd1);
        check("un_sticky", 32'(o_sticky_un), 32'd0);
        @(negedge clk);
        send(OP_ADD, 32'h7F7FFFFF, 32'h7F7FFFFF);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        check("ov2_valid", 32'(o_rsp_valid), 32'd1);
        check("ov2_flag", 32'(o_rsp_ov), 32'd1);
        check("set_beats_clear", 32'(o_sticky_ov), 32'd1);
        @(negedge clk);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        check("clear_alone", 32'(o_sticky_ov), 32'd0);

        // Reset with two ops in flight and one buffered
        rsp_ready = 1'b0;
        send(OP_ADD, 32'h200, 32'h1);
        send(OP_ADD, 32'h201, 32'h1);
        send(OP_ADD, 32'h202, 32'h1);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", 32'(o_rsp_valid), 32'd1);
        check("pre_rst_busy", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(o_rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_fpu_a", o_fpu_a, 32'd0);
        check("mid_rst_fpu_b", o_fpu_b, 32'd0);
        check("mid_rst_rsp_s", o_rsp_s, 32'd0);
        check("mid_rst_rsp_ov", 32'(o_rsp_ov), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(o_req_ready), 32'd1);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_rsp_valid) bad++;
        end
        check("no_stale_rsp", 32'(bad), 32'd0);
        check("post_rst_idle", 32'(o_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
